matrix_repeater: RTL and testbench

- Producer-side counterpart to the matrix accumulator.
- Captures one DIM1 x DIM0 matrix beat and replays it REPEAT times on a valid/ready stream, so a downstream matmul/accumulator chain can consume the same stationary operand over REPEAT partial-product steps.
- Sits between an operand buffer and the matmul datapath.
- Supports zero-bubble back-to-back matrices.

---
 rtl/matrix_repeater_pkg.sv | 20 ++
 rtl/matrix_repeater_counter.sv | 32 +++
 rtl/matrix_repeater.sv | 101 ++++++++++
 tb/tb_matrix_repeater.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/matrix_repeater_pkg.sv
// Shared definitions for the matrix stream blocks: default geometry,
// stream FSM state encoding and a counter-width helper.
package matrix_repeater_pkg;

  localparam int unsigned MAT_WIDTH = 32;
  localparam int unsigned MAT_DIM0  = 2;
  localparam int unsigned MAT_DIM1  = 2;
  localparam int unsigned MAT_ELEMS = MAT_DIM0 * MAT_DIM1;

  // Stream FSM states shared by matrix producers/consumers
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_SEND  = 1'b1;

  // Width able to hold 0..v-1, never narrower than one bit
  function automatic int unsigned clog2_min1(input int unsigned v);
    if (v <= 32'd1) return 32'd1;
    return 32'($clog2(v));
  endfunction

endpackage

// File: rtl/matrix_repeater_counter.sv
// Modulo-MAX emission counter with a clear and a terminal-count flag.
module repeat_counter
  import matrix_repeater_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       clear,
  output logic [clog2_min1(MAX)-1:0] count,
  output logic                       at_max
);

  localparam int unsigned CW = clog2_min1(MAX);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign count  = r_count;
  assign at_max = (r_count == CW'(MAX - 1));

endmodule

// File: rtl/matrix_repeater.sv
// Captures one matrix beat and replays it REPEAT times on a valid/ready
// stream; the next matrix is taken on the final handshake for zero bubbles.
module matrix_repeater
  import matrix_repeater_pkg::*;
#(
  parameter int unsigned REPEAT = 4,
  parameter int unsigned WIDTH  = MAT_WIDTH,
  parameter int unsigned DIM0   = MAT_DIM0,
  parameter int unsigned DIM1   = MAT_DIM1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH*DIM0*DIM1-1:0]   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH*DIM0*DIM1-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  localparam int unsigned DW = WIDTH * DIM0 * DIM1;
  localparam int unsigned CW = clog2_min1(REPEAT);

  logic          r_state;
  logic          w_state_nxt;
  logic [DW-1:0] r_hold;
  logic          w_capture;
  logic          w_inc;
  logic          w_clear;
  logic [CW-1:0] w_count;
  logic          w_at_max;

  repeat_counter #(
    .MAX (REPEAT)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_inc),
    .clear  (w_clear),
    .count  (w_count),
    .at_max (w_at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hold register only moves on an accepted input beat
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (w_capture) begin
      r_hold <= in_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_inc       = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (in_valid) begin
          w_capture   = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      default: begin
        if (out_ready) begin
          if (!w_at_max) begin
            w_inc = 1'b1;
          end else begin
            w_clear = 1'b1;
            if (in_valid) begin
              w_capture = 1'b1;
            end else begin
              w_state_nxt = ST_EMPTY;
            end
          end
        end
      end
    endcase
  end

  assign out_valid = (r_state == ST_SEND);
  assign out_last  = (r_state == ST_SEND) & w_at_max;
  assign out_data  = r_hold;
  // out_ready reaches in_ready combinationally; in_valid never does
  assign in_ready  = rst & ((r_state == ST_EMPTY) | (out_last & out_ready));

  a_count_flag: assert property (@(posedge clk) disable iff (!rst)
    w_at_max == (w_count == CW'(REPEAT - 1)));

endmodule

// File: tb/tb_matrix_repeater.sv
// Directed bench for matrix_repeater: REPEAT=4 and REPEAT=1 instances.
module tb_matrix_repeater;
  import matrix_repeater_pkg::*;

  localparam int unsigned DW = MAT_WIDTH * MAT_ELEMS;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW-1:0] in_data1, out_data1;
  logic          in_valid1, in_ready1, out_valid1, out_ready1, out_last1;

  int n_pass  = 0;
  int n_total = 0;
  int n_hs    = 0;

  always #5 clk = ~clk;

  matrix_repeater #(.REPEAT(4), .WIDTH(MAT_WIDTH), .DIM0(MAT_DIM0), .DIM1(MAT_DIM1)) u4 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  matrix_repeater #(.REPEAT(1), .WIDTH(MAT_WIDTH), .DIM0(MAT_DIM0), .DIM1(MAT_DIM1)) u1 (
    .clk(clk), .rst(rst),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1)
  );

  function automatic logic [DW-1:0] mk(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the REPEAT=4 instance: drive, check mid-cycle, advance
  task automatic cyc(input string tag, input logic iv, input logic [DW-1:0] id, input logic ordy,
                     input logic ev, input logic [DW-1:0] ed, input logic el, input logic er);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(ev));
    if (ev) chk({tag, ".out_data"}, out_data, ed);
    chk({tag, ".out_last"}, DW'(out_last), DW'(el));
    chk({tag, ".in_ready"}, DW'(in_ready), DW'(er));
    if (out_valid && out_ready) n_hs++;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input string tag, input logic iv, input logic [DW-1:0] id,
                      input logic ev, input logic [DW-1:0] ed, input logic er);
    in_valid1 = iv;
    in_data1  = id;
    @(negedge clk);
    chk({tag, ".out_valid"}, DW'(out_valid1), DW'(ev));
    if (ev) chk({tag, ".out_data"}, out_data1, ed);
    chk({tag, ".out_last"}, DW'(out_last1), DW'(ev));
    chk({tag, ".in_ready"}, DW'(in_ready1), DW'(er));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] ma, mb, mc, md, me;
    ma = mk(1, 2, 3, 4);
    mb = mk(5, 6, 7, 8);
    mc = mk(11, 12, 13, 14);
    md = mk(21, 22, 23, 24);
    me = mk(9, 9, 9, 9);

    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.out_valid", DW'(out_valid), '0);
    chk("rst.out_last",  DW'(out_last),  '0);
    chk("rst.out_data",  out_data,       '0);
    chk("rst.in_ready",  DW'(in_ready),  '0);
    chk("rst.u1.out_valid", DW'(out_valid1), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic replay
    cyc("idle",  1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    cyc("b.acc", 1'b1, ma, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++)
      cyc("b.rep", 1'b0, '0, 1'b1, 1'b1, ma, k == 4, k == 4);
    cyc("b.empty", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Back-to-back: B held valid from the cycle after A is taken
    cyc("bb.accA", 1'b1, ma, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++)
      cyc("bb.rep", k <= 4, mb, 1'b1, 1'b1, (k <= 4) ? ma : mb,
          (k == 4) || (k == 8), (k == 4) || (k == 8));
    cyc("bb.empty", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Backpressure at count=1 and on the last beat
    n_hs = 0;
    cyc("bp.acc", 1'b1, mc, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    cyc("bp.c0", 1'b0, '0, 1'b1, 1'b1, mc, 1'b0, 1'b0);
    repeat (3) cyc("bp.hold1", 1'b0, '0, 1'b0, 1'b1, mc, 1'b0, 1'b0);
    cyc("bp.c1", 1'b0, '0, 1'b1, 1'b1, mc, 1'b0, 1'b0);
    cyc("bp.c2", 1'b0, '0, 1'b1, 1'b1, mc, 1'b0, 1'b0);
    cyc("bp.hold3", 1'b0, '0, 1'b0, 1'b1, mc, 1'b1, 1'b0);
    cyc("bp.c3", 1'b0, '0, 1'b1, 1'b1, mc, 1'b1, 1'b1);
    chk("bp.handshakes", DW'(n_hs), DW'(4));
    cyc("bp.empty", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Reset after two of four emissions
    cyc("r.acc", 1'b1, md, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    cyc("r.c0", 1'b0, '0, 1'b1, 1'b1, md, 1'b0, 1'b0);
    cyc("r.c1", 1'b0, '0, 1'b1, 1'b1, md, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("r.in_ready_forced", DW'(in_ready), '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("r.out_valid", DW'(out_valid), '0);
    chk("r.out_data",  out_data,       '0);
    chk("r.out_last",  DW'(out_last),  '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("r.accE", 1'b1, me, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++)
      cyc("r.repE", 1'b0, '0, 1'b1, 1'b1, me, k == 4, k == 4);
    cyc("r.empty", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);

    // REPEAT=1 streaming at one beat per cycle
    cyc1("r1.acc10", 1'b1, mk(10, 11, 12, 13), 1'b0, '0, 1'b1);
    cyc1("r1.out10", 1'b1, mk(20, 21, 22, 23), 1'b1, mk(10, 11, 12, 13), 1'b1);
    cyc1("r1.out20", 1'b1, mk(30, 31, 32, 33), 1'b1, mk(20, 21, 22, 23), 1'b1);
    cyc1("r1.out30", 1'b0, '0, 1'b1, mk(30, 31, 32, 33), 1'b1);
    cyc1("r1.empty", 1'b0, '0, 1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
